// File: rtl/shader_pkg.sv
// Shared types and constants for the per-triangle diffuse shading unit.
// Holds the controller state encoding, Q-format helpers and the 3-component vector type.
package shader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int DEF_NORM_WIDTH = 16;
    localparam int DEF_NORM_FRAC  = 14;
    localparam int DOT_LAT        = 2;

    function automatic int oneQ(input int frac);
        return 1 << frac;
    endfunction

    function automatic int vec3Bits(input int compWidth);
        return 3 * compWidth;
    endfunction

    // Dot result keeps two guard bits above the product integer part once rescaled.
    function automatic int dotFullBits(input int compWidth, input int frac);
        return 2 + 2 * compWidth - frac;
    endfunction

    localparam int ONE = oneQ(DEF_NORM_FRAC);

    typedef logic signed [2:0][DEF_NORM_WIDTH-1:0] vec3_t;

endpackage

// File: rtl/light_dot_unit.sv
// Two-stage signed 3-term dot product: products in stage 1, sum in stage 2.
// A valid tag and slot index ride alongside the data so the parent can accumulate on arrival.
module light_dot_unit
    import shader_pkg::*;
#(
    parameter int NORM_WIDTH = 16,
    parameter int NORM_FRAC  = 14,
    parameter int SLOT_W     = 3
) (
    input  logic                                              clk_i,
    input  logic                                              rst_ni,
    input  logic                                              valid_i,
    input  logic [SLOT_W-1:0]                                 slot_i,
    input  logic [vec3Bits(NORM_WIDTH)-1:0]                   a_i,
    input  logic [vec3Bits(NORM_WIDTH)-1:0]                   b_i,
    output logic                                              valid_o,
    output logic [SLOT_W-1:0]                                 slot_o,
    output logic signed [dotFullBits(NORM_WIDTH, NORM_FRAC)-1:0] dot_o
);

    localparam int PROD_W = 2 * NORM_WIDTH;
    localparam int SUM_W  = PROD_W + 2;
    localparam int FULL   = dotFullBits(NORM_WIDTH, NORM_FRAC);

    logic signed [PROD_W-1:0] prod_d [3];
    logic signed [PROD_W-1:0] prod_q [3];
    logic signed [SUM_W-1:0]  sum_d;
    logic signed [SUM_W-1:0]  sum_q;
    logic                     valid1_q, valid2_q;
    logic [SLOT_W-1:0]        slot1_q, slot2_q;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            prod_d[i] = PROD_W'($signed(a_i[i*NORM_WIDTH +: NORM_WIDTH]))
                      * PROD_W'($signed(b_i[i*NORM_WIDTH +: NORM_WIDTH]));
        end
        sum_d = SUM_W'(prod_q[0]) + SUM_W'(prod_q[1]) + SUM_W'(prod_q[2]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            slot1_q  <= '0;
            slot2_q  <= '0;
            sum_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            valid1_q <= valid_i;
            valid2_q <= valid1_q;
            slot1_q  <= slot_i;
            slot2_q  <= slot1_q;
            sum_q    <= sum_d;
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    // Arithmetic shift drops the low fractional bits (rounds toward minus infinity).
    assign dot_o   = FULL'(sum_q >>> NORM_FRAC);
    assign valid_o = valid2_q;
    assign slot_o  = slot2_q;

endmodule

// File: rtl/multi_light_intensity.sv
// Diffuse shading for one triangle: backface test against the camera plus N directional lights and ambient.
// A single pipelined dot unit is shared across the camera slot and every light slot.
module multi_light_intensity
    import shader_pkg::*;
#(
    parameter int NORM_WIDTH = 16,
    parameter int NORM_FRAC  = 14,
    parameter int NUM_LIGHTS = 4,
    parameter int AMBIENT    = 1638
) (
    input  logic                                       clk_in,
    input  logic                                       rst_in,
    input  logic                                       valid_in,
    output logic                                       ready_out,
    input  logic [vec3Bits(NORM_WIDTH)-1:0]            tri_norm,
    input  logic [vec3Bits(NORM_WIDTH)-1:0]            cam_norm,
    input  logic [NUM_LIGHTS*vec3Bits(NORM_WIDTH)-1:0] light_dir,
    input  logic [NUM_LIGHTS-1:0]                      light_en,
    output logic [NORM_WIDTH-1:0]                      intensity_out,
    output logic                                       visible_out,
    output logic                                       valid_out,
    input  logic                                       ready_in
);

    localparam int VEC_W  = vec3Bits(NORM_WIDTH);
    localparam int FULL   = dotFullBits(NORM_WIDTH, NORM_FRAC);
    localparam int FULL1  = FULL + 1;
    localparam int ACC_W  = NORM_WIDTH + 5;
    localparam int SLOT_W = $clog2(NUM_LIGHTS + 1);
    localparam int CNT_W  = (SLOT_W > 2) ? SLOT_W : 2;

    localparam logic [ACC_W-1:0]      ONE_ACC  = ACC_W'(oneQ(NORM_FRAC));
    localparam logic [FULL1-1:0]      ONE_WIDE = FULL1'(oneQ(NORM_FRAC));
    localparam logic [NORM_WIDTH-1:0] ONE_OUT  = NORM_WIDTH'(oneQ(NORM_FRAC));
    localparam logic [ACC_W-1:0]      AMB_ACC  = ACC_W'(AMBIENT);

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [VEC_W-1:0]                  triNorm_q, camNorm_q;
    logic [NUM_LIGHTS*VEC_W-1:0]       lightDir_q;
    logic [NUM_LIGHTS-1:0]             lightEn_q;
    logic [ACC_W-1:0]                  accum_q;
    logic                              camVis_q;
    logic [NORM_WIDTH-1:0]             intensity_q;
    logic                              visibleOut_q, validOut_q;

    logic                              accept, issueValid, finalize;
    logic [VEC_W-1:0]                  opB;
    logic                              dotValid;
    logic [SLOT_W-1:0]                 dotSlot;
    logic signed [FULL-1:0]            dotVal;
    logic [FULL1-1:0]                  negDot;
    logic [ACC_W-1:0]                  contrib;
    logic                              slotEn, camFacing;
    logic [ACC_W-1:0]                  sumAmb;
    logic [NORM_WIDTH-1:0]             intensity_d;

    assign ready_out = rst_in && (state_q == IDLE);
    assign accept    = valid_in && ready_out;

    // Controller: ISSUE walks slot 0 (camera) then each light; DRAIN reuses the counter to cover the dot latency.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        issueValid = 1'b0;
        finalize   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                issueValid = 1'b1;
                if (cnt_q == CNT_W'(NUM_LIGHTS)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(DOT_LAT)) begin
                    finalize = 1'b1;
                    state_d  = HOLD;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (ready_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (accept) begin
            triNorm_q  <= tri_norm;
            camNorm_q  <= cam_norm;
            lightDir_q <= light_dir;
            lightEn_q  <= light_en;
        end
    end

    always_comb begin
        opB = camNorm_q;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            if (cnt_q == CNT_W'(i + 1)) begin
                opB = lightDir_q[i*VEC_W +: VEC_W];
            end
        end
    end

    light_dot_unit #(
        .NORM_WIDTH (NORM_WIDTH),
        .NORM_FRAC  (NORM_FRAC),
        .SLOT_W     (SLOT_W)
    ) u_dot (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .valid_i (issueValid),
        .slot_i  (SLOT_W'(cnt_q)),
        .a_i     (triNorm_q),
        .b_i     (opB),
        .valid_o (dotValid),
        .slot_o  (dotSlot),
        .dot_o   (dotVal)
    );

    // Lights point toward the scene, so a lit face has a negative dot; clamp each term to 1.0.
    always_comb begin
        negDot    = -{dotVal[FULL-1], dotVal};
        camFacing = dotVal[FULL-1] || (dotVal == '0);
        slotEn    = 1'b0;
        contrib   = '0;
        for (int i = 0; i < NUM_LIGHTS; i++) begin
            if (dotSlot == SLOT_W'(i + 1)) begin
                slotEn = lightEn_q[i];
            end
        end
        if (slotEn && dotVal[FULL-1]) begin
            contrib = (negDot > ONE_WIDE) ? ONE_ACC : ACC_W'(negDot);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            accum_q  <= '0;
            camVis_q <= 1'b0;
        end else if (accept) begin
            accum_q  <= '0;
            camVis_q <= 1'b0;
        end else if (dotValid) begin
            if (dotSlot == '0) begin
                camVis_q <= camFacing;
            end else begin
                accum_q <= accum_q + contrib;
            end
        end
    end

    always_comb begin
        sumAmb      = accum_q + AMB_ACC;
        intensity_d = '0;
        if (camVis_q) begin
            intensity_d = (sumAmb > ONE_ACC) ? ONE_OUT : sumAmb[NORM_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            validOut_q   <= 1'b0;
            visibleOut_q <= 1'b0;
            intensity_q  <= '0;
        end else if (finalize) begin
            validOut_q   <= 1'b1;
            visibleOut_q <= camVis_q;
            intensity_q  <= intensity_d;
        end else if ((state_q == HOLD) && ready_in) begin
            validOut_q <= 1'b0;
        end
    end

    assign valid_out     = validOut_q;
    assign visible_out   = visibleOut_q;
    assign intensity_out = intensity_q;

endmodule

// File: tb/tb_multi_light_intensity.sv
// Directed bench for multi_light_intensity: hand-computed shading results, fixed latency,
// output hold under backpressure and mid-transaction reset.
module tb_multi_light_intensity;
    import shader_pkg::*;

    localparam int W   = DEF_NORM_WIDTH;
    localparam int NL  = 4;
    localparam int LAT = NL + 4;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              valid_in;
    logic              ready_out;
    logic [3*W-1:0]    tri_norm;
    logic [3*W-1:0]    cam_norm;
    logic [NL*3*W-1:0] light_dir;
    logic [NL-1:0]     light_en;
    logic [W-1:0]      intensity_out;
    logic              visible_out;
    logic              valid_out;
    logic              ready_in;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        vec3_t      triV;
        vec3_t      camV;
        vec3_t      l0, l1, l2, l3;
        logic [3:0] en;
        logic       expVis;
        int         expInt;
    } case_t;

    case_t cases[$];

    multi_light_intensity #(
        .NORM_WIDTH (16),
        .NORM_FRAC  (14),
        .NUM_LIGHTS (NL),
        .AMBIENT    (1638)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .valid_in      (valid_in),
        .ready_out     (ready_out),
        .tri_norm      (tri_norm),
        .cam_norm      (cam_norm),
        .light_dir     (light_dir),
        .light_en      (light_en),
        .intensity_out (intensity_out),
        .visible_out   (visible_out),
        .valid_out     (valid_out),
        .ready_in      (ready_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic vec3_t mkVec(input int x, input int y, input int z);
        vec3_t v;
        v[0] = x[W-1:0];
        v[1] = y[W-1:0];
        v[2] = z[W-1:0];
        return v;
    endfunction

    task automatic addCase(input vec3_t t, input vec3_t c, input vec3_t a, input vec3_t b,
                           input vec3_t d, input vec3_t e, input logic [3:0] en,
                           input logic vis, input int inten);
        case_t k;
        k.triV = t; k.camV = c; k.l0 = a; k.l1 = b; k.l2 = d; k.l3 = e;
        k.en = en; k.expVis = vis; k.expInt = inten;
        cases.push_back(k);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic driveInputs(input case_t c);
        tri_norm  = c.triV;
        cam_norm  = c.camV;
        light_dir = {c.l3, c.l2, c.l1, c.l0};
        light_en  = c.en;
    endtask

    // Presents one request, waits for acceptance, then counts cycles until valid_out rises.
    task automatic applyStimulus(input case_t c, output int latency);
        int guard;
        driveInputs(c);
        valid_in = 1'b1;
        guard = 0;
        while (ready_out !== 1'b1 && guard < 50) begin
            @(posedge clk_in); #1;
            guard++;
        end
        if (ready_out !== 1'b1) begin
            checkOutput("accept_timeout", 32'(ready_out), 32'd1);
            valid_in = 1'b0;
            latency = -1;
        end else begin
            @(posedge clk_in); #1;
            valid_in = 1'b0;
            latency = 0;
            while (valid_out !== 1'b1 && latency < 40) begin
                @(posedge clk_in); #1;
                latency++;
            end
        end
    endtask

    task automatic runCase(input int idx);
        int lat;
        applyStimulus(cases[idx], lat);
        checkOutput($sformatf("case%0d_latency", idx), 32'(lat), 32'(LAT));
        checkOutput($sformatf("case%0d_visible", idx), 32'(visible_out), 32'(cases[idx].expVis));
        checkOutput($sformatf("case%0d_intensity", idx), 32'(intensity_out), 32'(cases[idx].expInt));
        @(posedge clk_in); #1;
        checkOutput($sformatf("case%0d_consumed", idx), 32'(valid_out), 32'd0);
    endtask

    initial begin
        int lat;
        int sawValid;
        vec3_t zero;
        zero = mkVec(0, 0, 0);

        // 0: camera behind the face -> culled
        addCase(mkVec(0,0,16384), mkVec(0,0,16384), mkVec(0,0,-16384), zero, zero, zero, 4'b0001, 1'b0, 0);
        // 1: full light plus ambient saturates
        addCase(mkVec(0,0,16384), mkVec(0,0,-16384), mkVec(0,0,-16384), zero, zero, zero, 4'b0001, 1'b1, ONE);
        // 2: half light plus ambient
        addCase(mkVec(0,0,16384), mkVec(0,0,-16384), mkVec(0,0,-8192), zero, zero, zero, 4'b0001, 1'b1, 9830);
        // 3: ambient only
        addCase(mkVec(0,0,16384), mkVec(0,0,-16384), mkVec(0,0,-8192), zero, zero, zero, 4'b0000, 1'b1, 1638);
        // 4: four half lights saturate
        addCase(mkVec(0,0,16384), mkVec(0,0,-16384), mkVec(0,0,-8192), mkVec(0,0,-8192),
                mkVec(0,0,-8192), mkVec(0,0,-8192), 4'b1111, 1'b1, ONE);
        // 5: second light faces away
        addCase(mkVec(0,0,16384), mkVec(0,0,-16384), mkVec(0,0,-8192), mkVec(0,0,16384), zero, zero,
                4'b0011, 1'b1, 9830);
        // 6: all three components active: 1638 + 8192 + 2048
        addCase(mkVec(8192,8192,8192), mkVec(-16384,0,0), mkVec(-8192,-8192,0), mkVec(0,0,-4096), zero, zero,
                4'b0011, 1'b1, 11878);
        // 7: camera dot exactly zero still visible
        addCase(mkVec(0,0,16384), mkVec(16384,0,0), mkVec(0,0,-8192), zero, zero, zero, 4'b0001, 1'b1, 9830);
        // 8: strong light disabled, enabled light is null
        addCase(mkVec(0,0,16384), mkVec(0,0,-16384), mkVec(0,0,-16384), zero, zero, zero, 4'b0010, 1'b1, 1638);

        rst_in    = 1'b0;
        valid_in  = 1'b0;
        ready_in  = 1'b1;
        driveInputs(cases[0]);
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("reset_valid", 32'(valid_out), 32'd0);
        checkOutput("reset_visible", 32'(visible_out), 32'd0);
        checkOutput("reset_intensity", 32'(intensity_out), 32'd0);
        checkOutput("reset_ready", 32'(ready_out), 32'd0);
        rst_in = 1'b1;
        #1;
        checkOutput("release_ready", 32'(ready_out), 32'd1);

        foreach (cases[i]) begin
            runCase(i);
        end

        $display("[TB] backpressure hold");
        ready_in = 1'b0;
        applyStimulus(cases[2], lat);
        checkOutput("hold_latency", 32'(lat), 32'(LAT));
        driveInputs(cases[3]);
        for (int k = 0; k < 5; k++) begin
            valid_in = 1'b1;
            @(posedge clk_in); #1;
            checkOutput($sformatf("hold%0d_valid", k), 32'(valid_out), 32'd1);
            checkOutput($sformatf("hold%0d_intensity", k), 32'(intensity_out), 32'd9830);
            checkOutput($sformatf("hold%0d_ready", k), 32'(ready_out), 32'd0);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        @(posedge clk_in); #1;
        checkOutput("hold_release_valid", 32'(valid_out), 32'd0);
        checkOutput("hold_release_ready", 32'(ready_out), 32'd1);
        runCase(6);

        $display("[TB] reset mid-transaction");
        driveInputs(cases[1]);
        valid_in = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        checkOutput("midreset_ready", 32'(ready_out), 32'd0);
        checkOutput("midreset_valid", 32'(valid_out), 32'd0);
        rst_in = 1'b1;
        #1;
        checkOutput("midreset_release_ready", 32'(ready_out), 32'd1);
        sawValid = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk_in); #1;
            if (valid_out === 1'b1) sawValid = 1;
        end
        checkOutput("midreset_no_valid", 32'(sawValid), 32'd0);
        runCase(2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish before 100000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
